mgmt_tx_frame_buffer: RTL

MGMT_TX_FRAME_BUFFER -- requirements
Module: mgmt_tx_frame_buffer

---
 rtl/mgmt_tx_frame_buffer_pkg.sv | 19 +
 rtl/mgmt_tx_frame_buffer_ram.sv | 24 ++
 rtl/mgmt_tx_frame_buffer.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/mgmt_tx_frame_buffer_pkg.sv
// Shared types for the management TX frame buffer:
// reader FSM states and the per-frame descriptor.
package EthernetTxBufferPkg;

  localparam int unsigned LEN_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    GAP
  } tx_state_e;

  typedef struct packed {
    logic [LEN_W-1:0] words;
    logic [2:0]       last_bv;
  } tx_desc_t;

endpackage

// File: rtl/mgmt_tx_frame_buffer_ram.sv
// Simple dual-port RAM: one write port, one read port,
// registered read data (one cycle latency).
module tx_buffer_ram #(
  parameter int DEPTH = 1024,
  parameter int WIDTH = 32,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/mgmt_tx_frame_buffer.sv
// Frame buffer between a management frame writer and the
// Ethernet MAC transmit bus, with commit/drop semantics.
module mgmt_tx_frame_buffer #(
  parameter int DEPTH           = 1024,
  parameter int MAX_FRAMES      = 16,
  parameter int MAX_FRAME_WORDS = 384
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        wr_start,
  input  logic                        wr_valid,
  input  logic [2:0]                  wr_bytes_valid,
  input  logic [31:0]                 wr_data,
  input  logic                        wr_commit,
  input  logic                        wr_drop,
  output logic                        wr_space_ok,
  input  logic                        mac_tx_ready,
  output logic                        tx_start,
  output logic                        tx_data_valid,
  output logic [2:0]                  tx_bytes_valid,
  output logic [31:0]                 tx_data,
  output logic [$clog2(MAX_FRAMES):0] frames_pending,
  output logic                        overflow
);

  import EthernetTxBufferPkg::*;

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int FW = $clog2(MAX_FRAMES) + 1;
  localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);
  localparam logic [LEN_W-1:0] MAX_LEN =
    LEN_W'(MAX_FRAME_WORDS);

  logic [PW-1:0]    wr_ptr, wr_ptr_n;
  logic [PW-1:0]    cm_ptr, cm_ptr_n;
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    tent_used, cm_used;
  logic [31:0]      free_words;
  logic [LEN_W-1:0] wr_cnt, wr_cnt_n;
  logic [2:0]       wr_bv, wr_bv_n;
  logic             wr_open, wr_open_n;
  logic             wr_blk, wr_blk_n;
  logic             ovf_n, ram_we, push;

  tx_desc_t         desc_mem [MAX_FRAMES];
  tx_desc_t         head;
  logic [FW-1:0]    dq_wp, dq_rp, dq_cnt;
  logic             dq_full, pop;

  tx_state_e        state, state_n;
  logic [LEN_W-1:0] left;
  logic [2:0]       cur_bv;
  logic             rd_en;
  logic [31:0]      rd_data;

  assign dq_cnt  = dq_wp - dq_rp;
  assign dq_full = dq_cnt == FW'(MAX_FRAMES);
  assign head    = desc_mem[dq_rp[FW-2:0]];

  assign tent_used  = wr_ptr - rd_ptr;
  assign cm_used    = cm_ptr - rd_ptr;
  assign free_words = 32'(DEPTH) - 32'(cm_used);

  assign wr_space_ok    =
    (free_words >= 32'(MAX_FRAME_WORDS)) && !dq_full;
  assign frames_pending = dq_cnt;

  // A blocked frame stays open so only wr_start revives it.
  always_comb begin
    wr_ptr_n  = wr_ptr;
    cm_ptr_n  = cm_ptr;
    wr_cnt_n  = wr_cnt;
    wr_bv_n   = wr_bv;
    wr_open_n = wr_open;
    wr_blk_n  = wr_blk;
    ovf_n     = 1'b0;
    ram_we    = 1'b0;
    push      = 1'b0;
    if (wr_start) begin
      wr_ptr_n  = cm_ptr;
      wr_cnt_n  = '0;
      wr_open_n = 1'b1;
      wr_blk_n  = 1'b0;
    end else if (wr_drop) begin
      wr_ptr_n  = cm_ptr;
      wr_cnt_n  = '0;
      wr_open_n = 1'b0;
    end else if (wr_open && !wr_blk) begin
      if (wr_valid) begin
        if (tent_used == DEPTH_P || wr_cnt == MAX_LEN) begin
          ovf_n    = 1'b1;
          wr_blk_n = 1'b1;
        end else begin
          ram_we   = 1'b1;
          wr_ptr_n = wr_ptr + 1'b1;
          wr_cnt_n = wr_cnt + 1'b1;
          wr_bv_n  = wr_bytes_valid;
        end
      end
      if (wr_commit && !ovf_n && wr_cnt_n != '0) begin
        if (dq_full) begin
          ovf_n = 1'b1;
        end else begin
          push     = 1'b1;
          cm_ptr_n = wr_ptr_n;
        end
      end
      if (wr_commit) wr_open_n = 1'b0;
      if (ovf_n) begin
        wr_ptr_n = cm_ptr;
        wr_cnt_n = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      cm_ptr   <= '0;
      wr_cnt   <= '0;
      wr_bv    <= '0;
      wr_open  <= 1'b0;
      wr_blk   <= 1'b0;
      overflow <= 1'b0;
      dq_wp    <= '0;
    end else begin
      wr_ptr   <= wr_ptr_n;
      cm_ptr   <= cm_ptr_n;
      wr_cnt   <= wr_cnt_n;
      wr_bv    <= wr_bv_n;
      wr_open  <= wr_open_n;
      wr_blk   <= wr_blk_n;
      overflow <= ovf_n;
      if (push) dq_wp <= dq_wp + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      desc_mem[dq_wp[FW-2:0]] <= '{
        words:   wr_cnt_n,
        last_bv: wr_bv_n
      };
    end
  end

  // START issues the first read so DATA never waits on RAM.
  always_comb begin
    state_n = state;
    pop     = 1'b0;
    rd_en   = 1'b0;
    unique case (state)
      IDLE: begin
        if (dq_cnt != '0 && mac_tx_ready) begin
          state_n = START;
          pop     = 1'b1;
        end
      end
      START: begin
        state_n = DATA;
        rd_en   = 1'b1;
      end
      DATA: begin
        if (left == LEN_W'(1)) state_n = GAP;
        else rd_en = 1'b1;
      end
      GAP: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      left   <= '0;
      cur_bv <= '0;
      rd_ptr <= '0;
      dq_rp  <= '0;
    end else begin
      state <= state_n;
      if (pop) begin
        left   <= head.words;
        cur_bv <= head.last_bv;
        dq_rp  <= dq_rp + 1'b1;
      end else if (state == DATA) begin
        left <= left - 1'b1;
      end
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  assign tx_start       = state == START;
  assign tx_data_valid  = state == DATA;
  assign tx_bytes_valid =
    (state != DATA)     ? 3'd0   :
    (left == LEN_W'(1)) ? cur_bv : 3'd4;
  assign tx_data = tx_data_valid ? rd_data : '0;

  tx_buffer_ram #(
    .DEPTH (DEPTH),
    .WIDTH (32)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (wr_ptr[AW-1:0]),
    .wdata (wr_data),
    .re    (rd_en),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (rd_data)
  );

endmodule
